// File: rtl/rom_loader_spi_writer.sv
// rtl/rom_loader_spi_writer.sv - writes loader-supplied words into serial SRAM via SPI WRITE (0x02)
module rom_loader_spi_writer #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rom_loader_load,
    input  logic                     rom_loader_sck,
    input  logic [DATA_WIDTH-1:0]    rom_loader_data,
    output logic                     rom_loader_ack,
    output logic                     rom_cs_n,
    output logic                     rom_sck,
    output logic                     rom_sio_oe,
    output logic                     rom_sio0_o,
    output logic                     rom_sio1_o,
    output logic                     rom_sio2_o,
    output logic                     rom_sio3_o,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] word_count
);

    localparam int FRAME_W  = 8 + 24 + DATA_WIDTH;
    localparam int ADDR_PAD = 23 - ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_sck_q;
    logic                     r_load_q;
    logic [FRAME_W-1:0]       r_shreg;
    logic [5:0]               r_bit_cnt;
    logic                     r_phase;
    logic [ADDRESS_WIDTH-1:0] r_word_count;

    logic                     w_strobe;
    logic                     w_load_rise;
    logic                     w_last_bit;
    logic [ADDRESS_WIDTH-1:0] w_wc_base;
    logic [23:0]              w_addr;

    assign w_strobe    = rom_loader_sck & ~r_sck_q & rom_loader_load;
    assign w_load_rise = rom_loader_load & ~r_load_q;
    assign w_last_bit  = (r_bit_cnt == 6'd0) && r_phase;
    // A session start in the same cycle as a strobe must already use address 0.
    assign w_wc_base   = w_load_rise ? '0 : r_word_count;
    assign w_addr      = {{ADDR_PAD{1'b0}}, w_wc_base, 1'b0};

    assign word_count  = r_word_count;
    assign rom_sio1_o  = 1'b0;
    assign rom_sio2_o  = 1'b1;
    assign rom_sio3_o  = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_strobe) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rom_cs_n       = 1'b1;
        rom_sck        = 1'b0;
        rom_sio_oe     = 1'b0;
        rom_sio0_o     = 1'b0;
        rom_loader_ack = 1'b0;
        busy           = 1'b0;
        case (r_state)
            S_SHIFT: begin
                rom_cs_n   = 1'b0;
                rom_sck    = r_phase;
                rom_sio_oe = 1'b1;
                rom_sio0_o = r_shreg[FRAME_W-1];
                busy       = 1'b1;
            end
            S_DONE: begin
                rom_loader_ack = 1'b1;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_q      <= 1'b0;
            r_load_q     <= 1'b0;
            r_word_count <= '0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_sck_q  <= rom_loader_sck;
            r_load_q <= rom_loader_load;

            if (w_load_rise) begin
                r_word_count <= '0;
            end else if (r_state == S_DONE) begin
                r_word_count <= r_word_count + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_shreg   <= {8'h02, w_addr, rom_loader_data};
                        r_bit_cnt <= 6'(FRAME_W - 1);
                        r_phase   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_phase <= ~r_phase;
                    // Advance to the next bit only after the SRAM has seen the rising SPI edge.
                    if (r_phase) begin
                        r_shreg   <= r_shreg << 1;
                        r_bit_cnt <= r_bit_cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
